// File: rtl/core_wb_pkg.sv
// Shared writeback-path constants and types for the register-file write port arbiter.
package core_wb_pkg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned WB_ID_W = 3;
  localparam int unsigned WAIT_W  = 4;

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_LSU = 1;
  localparam int unsigned WB_SRC_MUL = 2;
  localparam int unsigned WB_SRC_CSR = 3;

  typedef logic [WB_ID_W-1:0] wb_id_t;
  typedef logic [WAIT_W-1:0]  wait_cnt_t;

  // Index following idx, wrapping n-1 -> 0.
  function automatic wb_id_t wb_next_idx(input wb_id_t idx, input int unsigned n);
    if (32'(idx) + 1 >= n) return '0;
    return wb_id_t'(32'(idx) + 1);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-source valid/ready/sel/data in, registered regfile write port out.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import core_wb_pkg::*;

  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*REG_AW-1:0] req_sel;
  logic [NUM_REQ*XLEN-1:0]   req_data;
  logic                      wEn;
  logic [REG_AW-1:0]         write_sel;
  logic [XLEN-1:0]           write_data;
  wb_id_t                    grant_id;

  modport master (
    output hold, req_valid, req_sel, req_data,
    input  req_ready, wEn, write_sel, write_data, grant_id
  );

  modport slave (
    input  hold, req_valid, req_sel, req_data,
    output req_ready, wEn, write_sel, write_data, grant_id
  );
endinterface

// File: rtl/regfile_wb_arbiter_prio_pick.sv
// Combinational rotating priority picker: first set mask bit at or after start, wrapping.
module wb_prio_pick
  import core_wb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] mask,
  input  wb_id_t       start,
  output logic [N-1:0] onehot,
  output wb_id_t       idx,
  output logic         any
);
  // Rotation expressed as distance-from-start so all bit selects stay constant-indexed.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && mask[i] &&
            (((i >= 32'(start)) ? (i - 32'(start)) : (i + N - 32'(start))) == off)) begin
          any       = 1'b1;
          onehot[i] = 1'b1;
          idx       = wb_id_t'(i);
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port: starvation-guarded grant, registered output.
// Define REGFILE_WB_RR_EN for round-robin non-urgent selection; fixed priority otherwise.
module regfile_wb_arbiter
  import core_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_WAIT = 7
) (
  input logic                 clock,
  input logic                 reset,
  regfile_wb_arbiter_if.slave wb
);
  wait_cnt_t          wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] urgent_mask;
  logic [NUM_REQ-1:0] urg_oh;
  logic [NUM_REQ-1:0] norm_oh;
  logic [NUM_REQ-1:0] grant_oh;
  wb_id_t             urg_idx;
  wb_id_t             norm_idx;
  wb_id_t             grant_idx;
  wb_id_t             start_idx;
  logic               any_urg;
  logic               any_norm;
  logic               grant_en;
  logic               transfer;
  logic [REG_AW-1:0]  grant_sel;
  logic [XLEN-1:0]    grant_data;

  always_comb begin
    urgent_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      urgent_mask[i] = wb.req_valid[i] && (wait_cnt[i] == WAIT_W'(MAX_WAIT));
  end

`ifdef REGFILE_WB_RR_EN
  wb_id_t rr_ptr;

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (transfer)
      rr_ptr <= wb_next_idx(grant_idx, NUM_REQ);
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  wb_prio_pick #(.N(NUM_REQ)) u_pick_urgent (
    .mask   (urgent_mask),
    .start  ('0),
    .onehot (urg_oh),
    .idx    (urg_idx),
    .any    (any_urg)
  );

  wb_prio_pick #(.N(NUM_REQ)) u_pick_normal (
    .mask   (wb.req_valid),
    .start  (start_idx),
    .onehot (norm_oh),
    .idx    (norm_idx),
    .any    (any_norm)
  );

  always_comb begin
    grant_en  = !reset && !wb.hold;
    transfer  = grant_en && (any_urg || any_norm);
    grant_idx = any_urg ? urg_idx : norm_idx;
    grant_oh  = '0;
    if (transfer)
      grant_oh = any_urg ? urg_oh : norm_oh;
    wb.req_ready = grant_oh;
  end

  always_comb begin
    grant_sel  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_sel  = wb.req_sel[i*REG_AW +: REG_AW];
        grant_data = wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Counters age only while a source is left waiting; hold freezes all of them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        wait_cnt[i] <= '0;
    end else if (!wb.hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!wb.req_valid[i] || grant_oh[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // x0 writes are consumed but never enabled at the regfile.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb.wEn        <= 1'b0;
      wb.write_sel  <= '0;
      wb.write_data <= '0;
      wb.grant_id   <= '0;
    end else if (transfer) begin
      wb.wEn        <= (grant_sel != '0);
      wb.write_sel  <= grant_sel;
      wb.write_data <= grant_data;
      wb.grant_id   <= grant_idx;
    end else begin
      wb.wEn        <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (NUM_REQ=4, MAX_WAIT=7); honours REGFILE_WB_RR_EN.
module tb_regfile_wb_arbiter;
  import core_wb_pkg::*;

`ifdef REGFILE_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        wen;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [2:0]  id;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       hld;
    logic [3:0] vld;
    logic [3:0] rdy;
  } row_t;

  logic        clock;
  logic        reset;
  logic [4:0]  src_sel  [4];
  logic [31:0] src_data [4];
  logic [31:0] rf [32];
  out_t        sb [$];
  out_t        last;
  int          n_checks;
  int          n_fail;

  regfile_wb_arbiter_if #(.NUM_REQ(4)) wb();

  regfile_wb_arbiter #(.NUM_REQ(4), .MAX_WAIT(7)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    wb.req_sel  = '0;
    wb.req_data = '0;
    for (int i = 0; i < 4; i++) begin
      wb.req_sel[5*i +: 5]   = src_sel[i];
      wb.req_data[32*i +: 32] = src_data[i];
    end
  end

  // Behavioural negedge-writing regfile; writes on any wEn so a stray x0 write is visible.
  always @(negedge clock)
    if (wb.wEn) rf[wb.write_sel] <= wb.write_data;

  task automatic set_src(input int i, input logic [4:0] s, input logic [31:0] d);
    src_sel[i]  = s;
    src_data[i] = d;
  endtask

  task automatic push_exp(input logic rst, input logic [3:0] rdy);
    out_t e;
    e = '{wen: 1'b0, sel: last.sel, data: last.data, id: last.id};
    if (rst) e = '0;
    else begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) e = '{wen: (src_sel[i] != 5'd0), sel: src_sel[i], data: src_data[i], id: 3'(i)};
      end
    end
    last = e;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic hld, input logic [3:0] vld,
                       input logic [3:0] exp_rdy, output logic [3:0] rdy_obs,
                       output out_t o_obs, output out_t o_exp);
    @(negedge clock);
    reset        = rst;
    wb.hold      = hld;
    wb.req_valid = vld;
    #1 rdy_obs = wb.req_ready;
    push_exp(rst, exp_rdy);
    @(posedge clock);
    #1;
    o_obs = '{wen: wb.wEn, sel: wb.write_sel, data: wb.write_data, id: wb.grant_id};
    o_exp = (sb.size() != 0) ? sb.pop_front() : 'x;
  endtask

  task automatic test_reset;
    row_t rows [6] = '{'{1'b1, 1'b0, 4'b1111, 4'b0000}, '{1'b1, 1'b0, 4'b1111, 4'b0000},
                       '{1'b0, 1'b0, 4'b1111, 4'b0001}, '{1'b1, 1'b0, 4'b1110, 4'b0000},
                       '{1'b0, 1'b0, 4'b1110, 4'b0010}, '{1'b0, 1'b0, 4'b0000, 4'b0000}};
    logic [3:0] r; out_t o, e;
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'hC0DE_0000 + 32'(i));
    for (int k = 0; k < 6; k++) begin
      cycle(rows[k].rst, rows[k].hld, rows[k].vld, rows[k].rdy, r, o, e);
      n_checks++;
      if (r !== rows[k].rdy) begin n_fail++; $display("FAIL reset_ready k=%0d got %b want %b", k, r, rows[k].rdy); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_out k=%0d got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_two_sources;
    row_t rows [4] = '{'{1'b1, 1'b0, 4'b0000, 4'b0000}, '{1'b0, 1'b0, 4'b0101, 4'b0001},
                       '{1'b0, 1'b0, 4'b0100, 4'b0100}, '{1'b0, 1'b0, 4'b0000, 4'b0000}};
    logic [3:0] r; out_t o, e;
    set_src(0, 5'd5, 32'hDEAD_BEEF);
    set_src(2, 5'd7, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      cycle(rows[k].rst, rows[k].hld, rows[k].vld, rows[k].rdy, r, o, e);
      n_checks++;
      if (r !== rows[k].rdy) begin n_fail++; $display("FAIL two_src_ready k=%0d got %b want %b", k, r, rows[k].rdy); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL two_src_out k=%0d got %h want %h", k, o, e); end
    end
    n_checks++;
    if (rf[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL readback_x5 got %h want deadbeef", rf[5]); end
    n_checks++;
    if (rf[7] !== 32'h1234_5678) begin n_fail++; $display("FAIL readback_x7 got %h want 12345678", rf[7]); end
  endtask

  task automatic test_starvation;
    int g3;
    logic [3:0] v, x, r; out_t o, e;
    g3 = RR ? 1 : 7;
    set_src(0, 5'd1, 32'hAAAA_0000);
    set_src(3, 5'd9, 32'hBBBB_3333);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, r, o, e);
    for (int k = 0; k <= g3 + 2; k++) begin
      v = (k > g3 + 1) ? 4'b0000 : {(k <= g3), 3'b001};
      x = (k > g3 + 1) ? 4'b0000 : ((k == g3) ? 4'b1000 : 4'b0001);
      cycle(1'b0, 1'b0, v, x, r, o, e);
      n_checks++;
      if (r !== x) begin n_fail++; $display("FAIL starve_ready k=%0d got %b want %b", k, r, x); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL starve_out k=%0d got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_all_valid;
    logic [3:0] ft [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] x, r; out_t o, e;
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 10), 32'hA000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, r, o, e);
    for (int k = 0; k < 11; k++) begin
      x = RR ? 4'(1 << (k % 4)) : ft[k];
      cycle(1'b0, 1'b0, 4'b1111, x, r, o, e);
      n_checks++;
      if (r !== x) begin n_fail++; $display("FAIL all_valid_ready k=%0d got %b want %b", k, r, x); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL all_valid_out k=%0d got %h want %h", k, o, e); end
    end
    cycle(1'b0, 1'b0, 4'b0000, 4'b0000, r, o, e);
  endtask

  task automatic test_x0;
    row_t rows [3] = '{'{1'b1, 1'b0, 4'b0000, 4'b0000}, '{1'b0, 1'b0, 4'b0010, 4'b0010},
                       '{1'b0, 1'b0, 4'b0000, 4'b0000}};
    logic [3:0] r; out_t o, e;
    set_src(1, 5'd0, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      cycle(rows[k].rst, rows[k].hld, rows[k].vld, rows[k].rdy, r, o, e);
      n_checks++;
      if (r !== rows[k].rdy) begin n_fail++; $display("FAIL x0_ready k=%0d got %b want %b", k, r, rows[k].rdy); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL x0_out k=%0d got %h want %h", k, o, e); end
    end
    n_checks++;
    if (rf[0] !== 32'd0) begin n_fail++; $display("FAIL x0_readback got %h want 0", rf[0]); end
  endtask

  task automatic test_hold;
    row_t rows [6] = '{'{1'b1, 1'b0, 4'b0000, 4'b0000}, '{1'b0, 1'b1, 4'b0100, 4'b0000},
                       '{1'b0, 1'b1, 4'b0100, 4'b0000}, '{1'b0, 1'b1, 4'b0100, 4'b0000},
                       '{1'b0, 1'b0, 4'b0100, 4'b0100}, '{1'b0, 1'b0, 4'b0000, 4'b0000}};
    logic [3:0] r; out_t o, e;
    set_src(2, 5'd3, 32'h0BAD_F00D);
    for (int k = 0; k < 6; k++) begin
      cycle(rows[k].rst, rows[k].hld, rows[k].vld, rows[k].rdy, r, o, e);
      n_checks++;
      if (r !== rows[k].rdy) begin n_fail++; $display("FAIL hold_ready k=%0d got %b want %b", k, r, rows[k].rdy); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL hold_out k=%0d got %h want %h", k, o, e); end
    end
  endtask

  // src2 ages to 5, hold for 3: a frozen counter needs 2 more cycles to become urgent.
  task automatic test_hold_freeze;
    logic [3:0] v, x, r; logic h; out_t o, e;
    set_src(0, 5'd4, 32'h4444_0000);
    set_src(2, 5'd6, 32'h6666_2222);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, r, o, e);
    for (int k = 0; k < 13; k++) begin
      h = (k >= 5 && k < 8);
      v = (k == 12) ? 4'b0000 : ((k == 11) ? 4'b0001 : 4'b0101);
      x = h ? 4'b0000 : ((k == 10) ? 4'b0100 : ((k == 12) ? 4'b0000 : 4'b0001));
      cycle(1'b0, h, v, x, r, o, e);
      n_checks++;
      if (r !== x) begin n_fail++; $display("FAIL freeze_ready k=%0d got %b want %b", k, r, x); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL freeze_out k=%0d got %h want %h", k, o, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last     = '0;
    reset        = 1'b1;
    wb.hold      = 1'b0;
    wb.req_valid = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 4; i++) set_src(i, 5'd0, 32'd0);
    test_reset();
    test_two_sources();
    test_starvation();
    test_all_valid();
    test_x0();
    test_hold();
`ifndef REGFILE_WB_RR_EN
    test_hold_freeze();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
